// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave); at most one request outstanding.
interface if_stage_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing, imem handshake, IF/ID register.
// Define IF_STATIC_PREDICT_EN to predict backward branches and JAL as taken.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    if_stage_if.master  imem,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid,
    output logic        if_id_pred_taken
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic        hold_pred_q, hold_pred_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        if_id_pred_q, if_id_pred_d;

    logic [31:0] redir_pc;
    logic [31:0] next_pc;
    logic        pred_taken;
    logic        req_valid;
    logic        load;
    logic [31:0] load_pc, load_instr;
    logic        load_pred;

    assign redir_pc = redirect_pc & ~32'd3;

`ifdef IF_STATIC_PREDICT_EN
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [31:0] imm_b, imm_j, target;

    always_comb begin
        imm_b      = {{20{imem.imem_resp_data[31]}}, imem.imem_resp_data[7],
                      imem.imem_resp_data[30:25], imem.imem_resp_data[11:8], 1'b0};
        imm_j      = {{12{imem.imem_resp_data[31]}}, imem.imem_resp_data[19:12],
                      imem.imem_resp_data[20], imem.imem_resp_data[30:21], 1'b0};
        pred_taken = ((imem.imem_resp_data[6:0] == OP_BRANCH) && imem.imem_resp_data[31])
                   || (imem.imem_resp_data[6:0] == OP_JAL);
        target     = (pc_q + ((imem.imem_resp_data[6:0] == OP_JAL) ? imm_j : imm_b)) & ~32'd3;
        next_pc    = pred_taken ? target : pc_q + 32'd4;
    end
`else
    always_comb begin
        pred_taken = 1'b0;
        next_pc    = pc_q + 32'd4;
    end
`endif

    // pc_q is the address being requested (REQ) or outstanding (WAIT);
    // in HOLD/DRAIN it already holds the address of the next request.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        hold_pred_d  = hold_pred_q;
        req_valid    = 1'b0;
        load         = 1'b0;
        load_pc      = hold_pc_q;
        load_instr   = hold_instr_q;
        load_pred    = hold_pred_q;

        case (state_q)
            S_REQ: begin
                req_valid = 1'b1;
                if (redirect_valid) begin
                    pc_d = redir_pc;
                    if (imem.imem_req_ready) state_d = S_DRAIN;
                end else if (imem.imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = imem.imem_resp_valid ? S_REQ : S_DRAIN;
                end else if (imem.imem_resp_valid) begin
                    pc_d = next_pc;
                    if (stall) begin
                        hold_pc_d    = pc_q;
                        hold_instr_d = imem.imem_resp_data;
                        hold_pred_d  = pred_taken;
                        state_d      = S_HOLD;
                    end else begin
                        req_valid  = 1'b1;
                        load       = 1'b1;
                        load_pc    = pc_q;
                        load_instr = imem.imem_resp_data;
                        load_pred  = pred_taken;
                        state_d    = imem.imem_req_ready ? S_WAIT : S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = S_REQ;
                end else if (!stall) begin
                    load    = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: begin
                if (redirect_valid) pc_d = redir_pc;
                if (imem.imem_resp_valid) state_d = S_REQ;
            end
        endcase
    end

    always_comb begin
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pred_d  = if_id_pred_q;
        if_id_valid_d = if_id_valid_q;
        if (redirect_valid) begin
            if_id_valid_d = 1'b0;
        end else if (!stall) begin
            if_id_valid_d = load;
            if (load) begin
                if_id_pc_d    = load_pc;
                if_id_instr_d = load_instr;
                if_id_pred_d  = load_pred;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            hold_pc_q     <= '0;
            hold_instr_q  <= NOP;
            hold_pred_q   <= 1'b0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP;
            if_id_valid_q <= 1'b0;
            if_id_pred_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hold_pc_q     <= hold_pc_d;
            hold_instr_q  <= hold_instr_d;
            hold_pred_q   <= hold_pred_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_pred_q  <= if_id_pred_d;
        end
    end

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = (state_q == S_WAIT) ? next_pc : pc_q;
    assign if_id_pc            = if_id_pc_q;
    assign if_id_instruction   = if_id_instr_q;
    assign if_id_valid         = if_id_valid_q;
    assign if_id_pred_taken    = if_id_pred_q;

endmodule
